// File: rtl/guess_collector.sv
// Guess collector for the 16-player correlation game: gathers guesses, drives the comparator,
// captures its winner. Optional COLLECT timeout is enabled by defining GUESS_COLLECTOR_TIMEOUT_EN.
module guess_collector #(
   parameter int unsigned PLAYERS  = 16,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CORR_LAT = 2,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       target_load_i,
   input  logic [WIDTH-1:0]           target_in_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [3:0]                 in_player_i,
   input  logic [WIDTH-1:0]           in_num_i,
   output logic [PLAYERS*WIDTH-1:0]   num_flat_o,
   output logic [WIDTH-1:0]           target_num_o,
   output logic                       round_valid_o,
   input  logic [3:0]                 winner_in_i,
   output logic [3:0]                 winner_o,
   output logic                       winner_strobe_o,
   output logic [PLAYERS-1:0]         submitted_mask_o,
   output logic                       dup_err_o
);

   // One counter serves both the COLLECT timeout and the EVAL latency, so size it for both.
   localparam int unsigned CntMax = (TIMEOUT > CORR_LAT) ? TIMEOUT : CORR_LAT;
   localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

   typedef enum logic [1:0] {StIdle, StCollect, StEval, StReport} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [PLAYERS-1:0] mask_q, mask_d;
   logic [WIDTH-1:0]   target_q, target_d;
   logic [3:0]         winner_q, winner_d;
   logic               dup_q, dup_d;
   logic [WIDTH-1:0]   slots_q [PLAYERS];
   logic [WIDTH-1:0]   slots_d [PLAYERS];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      target_d = target_q;
      winner_d = winner_q;
      dup_d    = 1'b0;
      slots_d  = slots_q;

      unique case (state_q)
         StIdle: begin
            if (target_load_i) begin
               target_d = target_in_i;
               mask_d   = '0;
               for (int k = 0; k < PLAYERS; k++) begin
                  slots_d[k] = '1;
               end
               cnt_d    = '0;
               state_d  = StCollect;
            end
         end

         StCollect: begin
            if (in_valid_i) begin
               if (mask_q[in_player_i]) begin
                  dup_d = 1'b1;
               end else begin
                  slots_d[in_player_i] = in_num_i;
                  mask_d[in_player_i]  = 1'b1;
               end
            end
            // Decide on the post-write mask so the 16th beat's edge ends COLLECT.
            if (&mask_d) begin
               cnt_d   = '0;
               state_d = StEval;
            end
`ifdef GUESS_COLLECTOR_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               cnt_d   = '0;
               state_d = (|mask_d) ? StEval : StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end

         StEval: begin
            if (cnt_q == CntW'(CORR_LAT - 1)) begin
               winner_d = winner_in_i;
               cnt_d    = '0;
               state_d  = StReport;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StReport: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mask_q   <= '0;
         target_q <= '0;
         winner_q <= '0;
         dup_q    <= 1'b0;
         for (int k = 0; k < PLAYERS; k++) begin
            slots_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         target_q <= target_d;
         winner_q <= winner_d;
         dup_q    <= dup_d;
         for (int k = 0; k < PLAYERS; k++) begin
            slots_q[k] <= slots_d[k];
         end
      end
   end

   for (genvar g = 0; g < PLAYERS; g++) begin : g_flat
      assign num_flat_o[g*WIDTH +: WIDTH] = slots_q[g];
   end

   assign in_ready_o       = (state_q == StCollect);
   assign round_valid_o    = (state_q == StEval);
   assign winner_strobe_o  = (state_q == StReport);
   assign target_num_o     = target_q;
   assign winner_o         = winner_q;
   assign submitted_mask_o = mask_q;
   assign dup_err_o        = dup_q;

endmodule

// File: tb/tb_guess_collector.sv
// Self-checking bench for guess_collector; a behavioural model supplies the comparator result.
module tb_guess_collector;
   localparam int unsigned PLAYERS  = 16;
   localparam int unsigned WIDTH    = 32;
   localparam int unsigned CORR_LAT = 2;
   localparam int unsigned TIMEOUT  = 64;
   localparam int unsigned FW       = PLAYERS * WIDTH;

   logic               clk, rst;
   logic               target_load, in_valid, in_ready;
   logic [WIDTH-1:0]   target_in, in_num, target_num;
   logic [3:0]         in_player, winner_in, winner;
   logic [FW-1:0]      num_flat;
   logic               round_valid, winner_strobe, dup_err;
   logic [PLAYERS-1:0] submitted_mask;

   guess_collector dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .target_load_i    (target_load),
      .target_in_i      (target_in),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_player_i      (in_player),
      .in_num_i         (in_num),
      .num_flat_o       (num_flat),
      .target_num_o     (target_num),
      .round_valid_o    (round_valid),
      .winner_in_i      (winner_in),
      .winner_o         (winner),
      .winner_strobe_o  (winner_strobe),
      .submitted_mask_o (submitted_mask),
      .dup_err_o        (dup_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0]   m_slot [PLAYERS];
   logic [PLAYERS-1:0] m_mask;
   logic [WIDTH-1:0]   m_target;

   // Comparator model: closest guess to the target, lowest index on a tie.
   function automatic logic [3:0] ref_winner();
      logic [WIDTH-1:0] best, d;
      logic [3:0]       idx;
      best = '1;
      idx  = 4'd0;
      for (int k = 0; k < PLAYERS; k++) begin
         d = (m_slot[k] > m_target) ? m_slot[k] - m_target : m_target - m_slot[k];
         if (k == 0 || d < best) begin
            best = d;
            idx  = 4'(k);
         end
      end
      return idx;
   endfunction

   function automatic logic [FW-1:0] model_flat();
      logic [FW-1:0] r;
      for (int k = 0; k < PLAYERS; k++) r[k*WIDTH +: WIDTH] = m_slot[k];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string pfx);
      chk({pfx, "_flat"}, num_flat, model_flat());
      chk({pfx, "_target"}, FW'(target_num), FW'(m_target));
      chk({pfx, "_mask"}, FW'(submitted_mask), FW'(m_mask));
   endtask

   task automatic model_reset();
      for (int k = 0; k < PLAYERS; k++) m_slot[k] = '0;
      m_mask   = '0;
      m_target = '0;
   endtask

   task automatic start_round(input logic [WIDTH-1:0] t);
      chk("idle_not_ready", FW'(in_ready), FW'(1'b0));
      target_load = 1'b1;
      target_in   = t;
      tick();
      target_load = 1'b0;
      m_target    = t;
      m_mask      = '0;
      for (int k = 0; k < PLAYERS; k++) m_slot[k] = '1;
      winner_in   = ref_winner();
      chk("collect_ready", FW'(in_ready), FW'(1'b1));
      chk_model("round_start");
   endtask

   task automatic beat(input logic [3:0] p, input logic [WIDTH-1:0] v);
      logic exp_dup;
      in_valid  = 1'b1;
      in_player = p;
      in_num    = v;
      exp_dup   = m_mask[p];
      if (!exp_dup) begin
         m_slot[p] = v;
         m_mask[p] = 1'b1;
      end
      tick();
      in_valid  = 1'b0;
      winner_in = ref_winner();
      chk("beat_dup", FW'(dup_err), FW'(exp_dup));
      chk_model("beat");
   endtask

   task automatic finish_round(input logic [3:0] exp_w);
      int n;
      n = 0;
      while (round_valid === 1'b1 && n < 10) begin
         chk("eval_flat_stable", num_flat, model_flat());
         tick();
         n++;
      end
      chk("eval_len", FW'(n), FW'(CORR_LAT));
      chk("report_strobe", FW'(winner_strobe), FW'(1'b1));
      chk("report_winner", FW'(winner), FW'(exp_w));
      chk("report_rv_low", FW'(round_valid), FW'(1'b0));
      tick();
      chk("strobe_one_cycle", FW'(winner_strobe), FW'(1'b0));
      chk("back_idle", FW'(in_ready), FW'(1'b0));
      chk("winner_hold", FW'(winner), FW'(exp_w));
   endtask

   initial begin
      int ord [14];
      int n, j, tmp;
      rst = 1'b0; target_load = 1'b0; target_in = '0; in_valid = 1'b0;
      in_player = '0; in_num = '0; winner_in = '0;
      model_reset();

      // Reset with no other stimulus.
      #5 rst = 1'b1;
      #5 rst = 1'b0;
      #2;
      chk_model("reset");
      chk("reset_ready", FW'(in_ready), FW'(1'b0));
      chk("reset_rv", FW'(round_valid), FW'(1'b0));
      chk("reset_winner", FW'(winner), FW'(4'd0));
      chk("reset_strobe", FW'(winner_strobe), FW'(1'b0));
      chk("reset_dup", FW'(dup_err), FW'(1'b0));

      // Beats outside COLLECT are ignored.
      in_valid = 1'b1; in_player = 4'd0; in_num = 32'd7;
      tick();
      tick();
      in_valid = 1'b0;
      chk("idle_beat_dup", FW'(dup_err), FW'(1'b0));
      chk_model("idle_beat");

      // Reset during EVAL aborts the round.
      start_round($urandom);
      for (int p = 0; p < PLAYERS; p++) beat(4'(p), $urandom);
      chk("abort_eval_entry", FW'(round_valid), FW'(1'b1));
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk_model("abort");
      chk("abort_rv", FW'(round_valid), FW'(1'b0));
      chk("abort_ready", FW'(in_ready), FW'(1'b0));
      chk("abort_winner", FW'(winner), FW'(4'd0));
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_strobe", FW'(winner_strobe), FW'(1'b0));
      end
      chk("abort_winner_kept", FW'(winner), FW'(4'd0));

      // Full back-to-back round, slot 5 matches the target exactly.
      start_round(32'd60);
      beat(4'd0, 32'd100); beat(4'd1, 32'd200); beat(4'd2, 32'd300); beat(4'd3, 32'd400);
      beat(4'd4, 32'd50);  beat(4'd5, 32'd60);  beat(4'd6, 32'd70);  beat(4'd7, 32'd80);
      for (int p = 8; p < PLAYERS; p++) beat(4'(p), $urandom_range(32'hFFFF_FFFF, 32'd1000));
      chk("b2b_eval_entry", FW'(round_valid), FW'(1'b1));
      finish_round(4'd5);

      // Duplicate, then sparse beats with player 15 last.
      start_round($urandom);
      beat(4'd3, 32'd30);
      beat(4'd3, 32'd99);
      tick();
      chk("dup_one_cycle", FW'(dup_err), FW'(1'b0));
      j = 0;
      for (int p = 0; p < 15; p++) if (p != 3) begin ord[j] = p; j++; end
      for (int i = 13; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      for (int i = 0; i < 14; i++) begin
         beat(4'(ord[i]), $urandom);
         tick();
         chk("gap_rv_low", FW'(round_valid), FW'(1'b0));
         chk("gap_dup_low", FW'(dup_err), FW'(1'b0));
      end
      beat(4'd15, $urandom);
      chk("sparse_eval_entry", FW'(round_valid), FW'(1'b1));
      finish_round(ref_winner());

`ifdef GUESS_COLLECTOR_TIMEOUT_EN
      // Partial round expires into EVAL.
      start_round($urandom);
      beat(4'd2, $urandom);
      beat(4'd9, $urandom);
      n = 2;
      while (in_ready === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("tmo_cycles", FW'(n), FW'(TIMEOUT));
      chk("tmo_eval", FW'(round_valid), FW'(1'b1));
      chk_model("tmo");
      finish_round(ref_winner());

      // Empty round expires back to IDLE.
      start_round($urandom);
      n = 0;
      while (in_ready === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("tmo_empty_cycles", FW'(n), FW'(TIMEOUT));
      chk("tmo_empty_rv", FW'(round_valid), FW'(1'b0));
      for (int i = 0; i < 4; i++) begin
         chk("tmo_empty_no_strobe", FW'(winner_strobe), FW'(1'b0));
         tick();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
